// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel-clock-enable divider, one-tick source latency and aligned colour/sync/de outputs.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 4,
  parameter int   CNT_W    = 11
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] pixel_color,
  output logic                 pix_ce,
  output logic [CNT_W-1:0]     x_coord,
  output logic [CNT_W-1:0]     y_coord,
  output logic                 pix_req,
  output logic                 frame_start,
  output logic                 line_start,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_b, vs_b;
  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  // stage A counts, stage B publishes the pre-increment position, stage C presents the previous one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_coord     <= '0;
      y_coord     <= '0;
      pix_req     <= 1'b0;
      hs_b        <= 1'b0;
      vs_b        <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else if (!en) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_coord     <= '0;
      y_coord     <= '0;
      pix_req     <= 1'b0;
      hs_b        <= 1'b0;
      vs_b        <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      div         <= div_nxt;
      pix_ce      <= (div_nxt == DIV_LAST);
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_ce) begin
        h_cnt       <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
        if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        x_coord     <= h_cnt;
        y_coord     <= v_cnt;
        pix_req     <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_b        <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        if (h_cnt == '0) vs_b <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        vga_r       <= pix_req ? pixel_color[COLOR_W-1:0] : '0;
        vga_g       <= pix_req ? pixel_color[2*COLOR_W-1:COLOR_W] : '0;
        vga_b       <= pix_req ? pixel_color[3*COLOR_W-1:2*COLOR_W] : '0;
        de          <= pix_req;
        hsync       <= hs_b ? HS_POL : ~HS_POL;
        vsync       <= vs_b ? VS_POL : ~VS_POL;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three parameter sets run side by side, each checked every clk against a pixel-index reference model.
module tb_vga_timing_gen;
  localparam int N = 3;
  localparam int CD [N] = '{4, 1, 3};
  localparam int HA [N] = '{640, 8, 10};
  localparam int HF [N] = '{16, 2, 3};
  localparam int HS [N] = '{96, 2, 4};
  localparam int HB [N] = '{48, 2, 5};
  localparam int VA [N] = '{480, 4, 5};
  localparam int VF [N] = '{10, 1, 2};
  localparam int VS [N] = '{2, 1, 3};
  localparam int VB [N] = '{33, 1, 2};
  localparam bit HP [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit VP [N] = '{1'b0, 1'b1, 1'b1};

  logic clk = 1'b0, rstn = 1'b1, en = 1'b0;
  logic [11:0] pc [N];
  logic ce_o [N], req_o [N], fs_o [N], ls_o [N], hs_o [N], vs_o [N], de_o [N];
  logic [10:0] x_o [N], y_o [N];
  logic [3:0] r_o [N], g_o [N], b_o [N];

  for (genvar i = 0; i < N; i++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV(CD[i]), .H_ACTIVE(HA[i]), .H_FP(HF[i]), .H_SYNC(HS[i]), .H_BP(HB[i]),
      .V_ACTIVE(VA[i]), .V_FP(VF[i]), .V_SYNC(VS[i]), .V_BP(VB[i]),
      .HS_POL(HP[i]), .VS_POL(VP[i]), .COLOR_W(4), .CNT_W(11)
    ) dut (
      .clk(clk), .rstn(rstn), .en(en), .pixel_color(pc[i]),
      .pix_ce(ce_o[i]), .x_coord(x_o[i]), .y_coord(y_o[i]), .pix_req(req_o[i]),
      .frame_start(fs_o[i]), .line_start(ls_o[i]),
      .vga_r(r_o[i]), .vga_g(g_o[i]), .vga_b(b_o[i]),
      .hsync(hs_o[i]), .vsync(vs_o[i]), .de(de_o[i])
    );
  end

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int t;
  int k [N];
  bit prev_ce [N];
  logic [11:0] col [N];

  function automatic logic [40:0] obs(int g);
    return {ce_o[g], x_o[g], y_o[g], req_o[g], fs_o[g], ls_o[g], r_o[g], g_o[g], b_o[g], hs_o[g], vs_o[g], de_o[g]};
  endfunction

  function automatic logic [40:0] rst_vec(int g);
    return {38'd0, ~HP[g], ~VP[g], 1'b0};
  endfunction

  // expected outputs after kk pixel ticks: coordinate = pixel kk-1, presented pixel = kk-2
  function automatic logic [40:0] model(int g, bit ce, bit loaded, int kk, logic [11:0] c, bit xm);
    int ht, vt, p, x, y, qx, qy;
    bit req, fs, ls, act, hs, vs;
    logic [3:0] r, gg, b;
    ht = HA[g] + HF[g] + HS[g] + HB[g];
    vt = VA[g] + VF[g] + VS[g] + VB[g];
    x = 0; y = 0; req = 0; fs = 0; ls = 0; act = 0; hs = 0; vs = 0;
    r = 0; gg = 0; b = 0;
    if (kk >= 1) begin
      p = kk - 1;
      x = p % ht;
      y = (p / ht) % vt;
      req = x < HA[g] && y < VA[g];
      fs = loaded && x == 0 && y == 0;
      ls = loaded && x == 0;
    end
    if (kk >= 2) begin
      qx = (kk - 2) % ht;
      qy = ((kk - 2) / ht) % vt;
      act = qx < HA[g] && qy < VA[g];
      hs = qx >= HA[g] + HF[g] && qx < HA[g] + HF[g] + HS[g];
      vs = qy >= VA[g] + VF[g] && qy < VA[g] + VF[g] + VS[g];
      if (act) begin
        if (xm) begin
          r = 4'(qx); gg = 4'(qx); b = 4'(qx);
        end else {b, gg, r} = c;
      end
    end
    return {ce, 11'(x), 11'(y), req, fs, ls, r, gg, b, hs ? HP[g] : ~HP[g], vs ? VP[g] : ~VP[g], act};
  endfunction

  task automatic clear_model();
    t = 0;
    for (int g = 0; g < N; g++) begin
      k[g] = 0; prev_ce[g] = 0; col[g] = '0;
    end
  endtask

  // entered and left at a negedge
  task automatic run_check(input int n, input bit xm, input string name);
    logic [40:0] e;
    bit ce;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < N; g++) pc[g] = xm ? {3{x_o[g][3:0]}} : 12'($urandom);
      @(posedge clk); #1;
      t++;
      for (int g = 0; g < N; g++) begin
        if (prev_ce[g]) begin
          k[g]++; col[g] = pc[g];
        end
        ce = (t % CD[g]) == CD[g] - 1;
        e = model(g, ce, prev_ce[g], k[g], col[g], xm);
        prev_ce[g] = ce;
        vectors++;
        if (obs(g) !== e) begin
          miscompares++;
          $display("FAIL %s cfg%0d t=%0d got=%h expected=%h", name, g, t, obs(g), e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int g = 0; g < N; g++) begin
        vectors++;
        if (obs(g) !== rst_vec(g)) begin
          miscompares++;
          $display("FAIL %s cfg%0d cyc=%0d got=%h expected=%h", name, g, i, obs(g), rst_vec(g));
        end
      end
      @(negedge clk);
    end
    clear_model();
  endtask

  task automatic test_reset();
    for (int g = 0; g < N; g++) pc[g] = 12'hABC;
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      vectors++;
      if (obs(g) !== rst_vec(g)) begin
        miscompares++;
        $display("FAIL reset_async cfg%0d got=%h expected=%h", g, obs(g), rst_vec(g));
      end
    end
    @(negedge clk);
    idle_check(3, "reset_hold");
  endtask

  task automatic test_frames_random();
    rstn = 1'b1; en = 1'b1;
    clear_model();
    run_check(12000, 1'b0, "frames_random");
  endtask

  task automatic test_en_drop_latency();
    en = 1'b0;
    idle_check(3, "en_drop");
    en = 1'b1;
    run_check(3000, 1'b1, "source_latency");
  endtask

  task automatic test_reset_midline();
    en = 1'b0;
    idle_check(1, "en_restart");
    en = 1'b1;
    run_check(1300, 1'b0, "pre_reset");
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      vectors++;
      if (obs(g) !== rst_vec(g)) begin
        miscompares++;
        $display("FAIL midline_reset cfg%0d got=%h expected=%h", g, obs(g), rst_vec(g));
      end
    end
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_check(10, "en_low_hold");
    en = 1'b1;
    run_check(600, 1'b0, "after_restart");
  endtask

  initial begin
    test_reset();
    test_frames_random();
    test_en_drop_latency();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with a built-in pixel-clock-enable divider, selectable sync polarity and a configurable colour depth. It runs on the system clock and advances one pixel per pix_ce. It publishes the coordinate being requested and a pixel request strobe. It samples the pixel source one pixel tick later and drives colour, hsync, vsync and de aligned to each other. It sits between the frame/pixel source logic and the board VGA pins.

Parameters:
CLK_DIV, 4, clk cycles per pixel (>=1); 100 MHz/4 = 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted hsync level
VS_POL, 0, asserted vsync level
COLOR_W, 4, bits per colour channel
CNT_W, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous, active-low reset
en  in  1  run enable; low = synchronous clear to reset state
pixel_color  in  3*COLOR_W  {blue,green,red}; red = [COLOR_W-1:0]
pix_ce  out  1  one-clk pixel enable strobe
x_coord  out  CNT_W  requested pixel column
y_coord  out  CNT_W  requested pixel line
pix_req  out  1  requested coordinate is inside the active area
frame_start  out  1  one-clk pulse at the first presentation of x=0,y=0
line_start  out  1  one-clk pulse at every presentation of x=0 (all lines)
vga_r, vga_g, vga_b  out  COLOR_W each  colour outputs
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  display enable, aligned with colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (rstn low, async) and en low (sync, next clk) both force the same state:
  - div=0, h_cnt=0, v_cnt=0, pix_ce=0.
  - x_coord=0, y_coord=0, pix_req=0, frame_start=0, line_start=0, de=0.
  - vga_r, vga_g, vga_b = 0; hsync=~HS_POL, vsync=~VS_POL.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_ce is registered high for the clk in which div==CLK_DIV-1. With CLK_DIV=1, pix_ce is high every clk after reset release.
- Stage A, on each pix_ce:
  - h_cnt increments, wrapping at H_TOTAL-1 to 0.
  - On that h wrap, v_cnt increments, wrapping at V_TOTAL-1 to 0.
- Stage B, on the same pix_ce, registers the pre-increment h_cnt/v_cnt:
  - x_coord <= h_cnt; y_coord <= v_cnt.
  - pix_req <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_b asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_b asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Line-granular: vs_b changes only with the h_cnt=0 load.
- frame_start: high for exactly the one clk after the Stage B load with x=0,y=0. line_start: same rule for any load with x=0. Both are 0 otherwise.
- Stage C, on the next pix_ce:
  - pixel_color is sampled.
  - vga_{r,g,b} <= pix_req ? channel slices : 0.
  - de <= pix_req; hsync/vsync <= registered hs_b/vs_b at the parameter polarity.
- Latency and source timing:
  - Colour and syncs appear one pixel tick after the coordinate.
  - The source has CLK_DIV clk cycles to present pixel_color after x_coord changes.
  - hsync, vsync and de are mutually aligned at every pixel.
- The first pix_ce after reset loads x=0,y=0; frame_start pulses one clk later.
- Reset or en drop mid-frame: the frame is abandoned and restarts from x=0,y=0 on the next run. No partial sync pulse is extended.
- pixel_color outside the active area is ignored.

Test Plan:
- Defaults, pixel_color=12'hABC constant, run 2 frames:
  - vga_r=C, vga_g=B, vga_b=A while de=1; all channels 0 while de=0.
  - de high 640 pix = 2560 clk per line.
- Defaults, sync measurement:
  - hsync period 3200 clk, low width 384 clk, falls 16 pix after de falls.
  - vsync period 1,680,000 clk, low for 2 lines, falls at the start of line 490.
- Defaults, strobes: frame_start exactly once per 1,680,000 clk; line_start 525 times per frame.
- CLK_DIV=1, H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1:
  - pix_ce constant high; x_coord sequence 0..13 then wraps.
  - hsync high at x=10..11 delayed one clk; vsync high during line 5.
- Source latency check: pixel_color=x_coord[3:0] replicated → vga_r at each output pixel equals the x of the previous coordinate load.
- rstn pulsed low mid-line (x=300, y=200), then en held low 10 clk:
  - All outputs are at reset values immediately and during en=0.
  - After release, the first coordinate is 0,0 with a frame_start pulse.
